// File: rtl/uart_rx_handshake.sv
// uart_rx_handshake: UART receiver with false-start rejection, parity/framing errors and a valid/ready holding register; define RX_MAJORITY_EN for 2-of-3 majority sampling
module uart_rx_handshake #(
  parameter int divisor = 16,
  parameter int rx_num_bits = 8,
  parameter int parity = 0
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic                   RX,
  output logic [rx_num_bits-1:0] data_out,
  output logic                   data_valid,
  input  logic                   data_ready,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   overrun
);
  localparam int CW = $clog2(divisor + 2);
  localparam int IW = $clog2(rx_num_bits + 1);
`ifdef RX_MAJORITY_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif
  localparam logic [CW-1:0] S_START = CW'(divisor / 2 - 1 + OFS);
  localparam logic [CW-1:0] S_BIT = CW'(divisor - 1 + OFS);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PAR = 3'd3, STOP = 3'd4, BRK = 3'd5;
  logic rx_m_q, rx_s_q, rx_p_q, samp, hit;
  logic [2:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [rx_num_bits-1:0] shift_q, shift_d, data_out_q, data_out_d;
  logic perr_q, perr_d, data_valid_q, data_valid_d, parity_err_q, parity_err_d;
  logic frame_err_q, frame_err_d, overrun_q, overrun_d;
`ifdef RX_MAJORITY_EN
  logic rx_pp_q;
  always_ff @(posedge clk) rx_pp_q <= RST ? 1'b1 : rx_p_q;
  assign samp = (rx_pp_q & rx_p_q) | (rx_pp_q & rx_s_q) | (rx_p_q & rx_s_q);
`else
  assign samp = rx_s_q;
`endif
  assign hit = cnt_q == (state_q == START ? S_START : S_BIT);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    shift_d = shift_q;
    perr_d = perr_q;
    data_out_d = data_out_q;
    data_valid_d = data_valid_q & ~data_ready;
    parity_err_d = parity_err_q;
    frame_err_d = frame_err_q;
    overrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        state_d = (rx_p_q & ~rx_s_q) ? START : IDLE;
      end
      START: if (hit) begin
        cnt_d = '0;
        idx_d = '0;
        perr_d = 1'b0;
        state_d = samp ? IDLE : DATA;
      end
      DATA: if (hit) begin
        cnt_d = '0;
        shift_d = {samp, shift_q[rx_num_bits-1:1]};
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(rx_num_bits - 1)) state_d = (parity != 0) ? PAR : STOP;
      end
      PAR: if (hit) begin
        cnt_d = '0;
        perr_d = (parity == 1) ? ~(^shift_q ^ samp) : (^shift_q ^ samp);
        state_d = STOP;
      end
      STOP: if (hit) begin
        cnt_d = '0;
        state_d = samp ? IDLE : BRK;
        if (~data_valid_q | data_ready) begin
          data_out_d = shift_q;
          data_valid_d = 1'b1;
          parity_err_d = (parity != 0) && perr_q;
          frame_err_d = ~samp;
        end else overrun_d = 1'b1;
      end
      BRK: begin
        cnt_d = '0;
        state_d = rx_s_q ? IDLE : BRK;
      end
      default: begin
        cnt_d = '0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (RST) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_p_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      perr_q <= 1'b0;
      data_out_q <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rx_m_q <= RX;
      rx_s_q <= rx_m_q;
      rx_p_q <= rx_s_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      perr_q <= perr_d;
      data_out_q <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q <= frame_err_d;
      overrun_q <= overrun_d;
    end
  end
  assign data_out = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err = frame_err_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_uart_rx_handshake.sv
// tb_uart_rx_handshake: table-driven bench for uart_rx_handshake (8N1 and 8E1 instances)
module tb_uart_rx_handshake;
  logic clk = 1'b0, rst = 1'b1, line = 1'b1, sel = 1'b0, ready = 1'b1;
  logic rx0, rx1, dv0, dv1, pe0, pe1, fe0, fe1, ov0, ov1;
  logic [7:0] do0, do1;
  int total = 0, bad = 0, vc0 = 0, vc1 = 0, oc0 = 0, rd0 = 0, rd1 = 0;
  logic [9:0] q0[$], q1[$];
  typedef struct {logic s; logic [7:0] d; logic pb; logic [7:0] ed; logic ep;} vec_t;
  vec_t tv[6];
  assign rx0 = sel ? 1'b1 : line;
  assign rx1 = sel ? line : 1'b1;
  uart_rx_handshake #(.divisor(16), .rx_num_bits(8), .parity(0)) dut (
    .clk(clk), .RST(rst), .RX(rx0), .data_out(do0), .data_valid(dv0), .data_ready(ready),
    .parity_err(pe0), .frame_err(fe0), .overrun(ov0));
  uart_rx_handshake #(.divisor(16), .rx_num_bits(8), .parity(2)) dut_p (
    .clk(clk), .RST(rst), .RX(rx1), .data_out(do1), .data_valid(dv1), .data_ready(ready),
    .parity_err(pe1), .frame_err(fe1), .overrun(ov1));
  always #5 clk = ~clk;
  always @(negedge clk) if (!rst) begin
    if (dv0) vc0 <= vc0 + 1;
    if (dv1) vc1 <= vc1 + 1;
    if (ov0) oc0 <= oc0 + 1;
    if (dv0 && ready) q0.push_back({do0, pe0, fe0});
    if (dv1 && ready) q1.push_back({do1, pe1, fe1});
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic bit_out(input logic b);
    line = b;
    repeat (16) tick;
  endtask
  task automatic send(input logic [7:0] d, input logic has_par, input logic pb, input logic sb);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    if (has_par) bit_out(pb);
    bit_out(sb);
  endtask
  task automatic chk_word(input string n, input logic s, input logic [7:0] ed, input logic ep, input logic ef);
    int sz;
    logic [9:0] w;
    sz = s ? q1.size() - rd1 : q0.size() - rd0;
    chk({n, " count"}, sz, 1);
    if (sz > 0) begin
      w = s ? q1[rd1] : q0[rd0];
      chk({n, " data"}, w[9:2], ed);
      chk({n, " parity_err"}, w[1], ep);
      chk({n, " frame_err"}, w[0], ef);
    end
    if (s) rd1 = q1.size();
    else rd0 = q0.size();
  endtask
  initial begin
    int v;
    tv[0] = '{1'b0, 8'hA5, 1'b0, 8'hA5, 1'b0};
    tv[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    tv[2] = '{1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0};
    tv[3] = '{1'b1, 8'h07, 1'b1, 8'h07, 1'b0};
    tv[4] = '{1'b1, 8'h07, 1'b0, 8'h07, 1'b1};
    tv[5] = '{1'b1, 8'h3C, 1'b0, 8'h3C, 1'b0};
    repeat (3) tick;
    @(negedge clk);
    chk("reset data_out", do0, 0);
    chk("reset data_valid", dv0, 0);
    chk("reset parity_err", pe0, 0);
    chk("reset frame_err", fe0, 0);
    chk("reset overrun", ov0, 0);
    chk("reset data_valid par", dv1, 0);
    tick;
    rst = 1'b0;
    repeat (500) tick;
    chk("idle no valid", vc0, 0);
    for (int i = 0; i < 6; i++) begin
      sel = tv[i].s;
      v = tv[i].s ? vc1 : vc0;
      send(tv[i].d, tv[i].s, tv[i].pb, 1'b1);
      chk($sformatf("vec%0d valid width", i), (tv[i].s ? vc1 : vc0) - v, 1);
      chk_word($sformatf("vec%0d", i), tv[i].s, tv[i].ed, tv[i].ep, 1'b0);
    end
    sel = 1'b0;
    line = 1'b0;
    repeat (5) tick;
    line = 1'b1;
    repeat (30) tick;
    chk("false start no word", q0.size() - rd0, 0);
    send(8'h3C, 1'b0, 1'b0, 1'b1);
    chk_word("after false start", 1'b0, 8'h3C, 1'b0, 1'b0);
    v = vc0;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(v[0] ^ v[0] ^ ((8'h55 >> i) & 1'b1));
    line = 1'b0;
    repeat (41 * 16) tick;
    chk("break valid width", vc0 - v, 1);
    chk_word("break", 1'b0, 8'h55, 1'b0, 1'b1);
    line = 1'b1;
    repeat (32) tick;
    send(8'h81, 1'b0, 1'b0, 1'b1);
    chk_word("after break", 1'b0, 8'h81, 1'b0, 1'b0);
    ready = 1'b0;
    v = oc0;
    send(8'h11, 1'b0, 1'b0, 1'b1);
    chk("overrun none on first", oc0 - v, 0);
    send(8'h22, 1'b0, 1'b0, 1'b1);
    chk("overrun pulse count", oc0 - v, 1);
    chk("overrun held data", do0, 8'h11);
    chk("overrun held valid", dv0, 1);
    ready = 1'b1;
    @(negedge clk);
    chk("handshake valid before", dv0, 1);
    @(negedge clk);
    chk("handshake valid after", dv0, 0);
    chk_word("overrun held", 1'b0, 8'h11, 1'b0, 1'b0);
    tick;
`ifdef RX_MAJORITY_EN
    repeat (20) tick;
    bit_out(1'b0);
    line = 1'b0;
    repeat (9) tick;
    line = 1'b1;
    tick;
    line = 1'b0;
    repeat (6) tick;
    for (int i = 1; i < 8; i++) bit_out((8'h5A >> i) & 1'b1);
    bit_out(1'b1);
    chk_word("glitch reject", 1'b0, 8'h5A, 1'b0, 1'b0);
`endif
    repeat (20) tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
